// File: rtl/uart_pkg.sv
// Shared definitions for the UART packet path: state encoding, buffer geometry
// and the byte-count clamp that both the FIFO side and the TX side apply.
package uart_pkg;

  localparam int DEF_DATA_SIZE      = 8;
  localparam int DEF_ADDR_SPACE_EXP = 3;
  localparam int DEPTH              = 2**DEF_ADDR_SPACE_EXP;
  localparam int PACKED_W           = DEF_DATA_SIZE*DEPTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } tx_state_t;

  // Counts larger than the buffer depth mean "the whole buffer".
  function automatic int unsigned clamp_count(input int unsigned cnt,
                                              input int unsigned depth);
    return (cnt > depth) ? depth : cnt;
  endfunction

endpackage

// File: rtl/uart_tx_packet_sender.sv
// Drains a packed FIFO word into the UART TX core one byte at a time (word 0 first),
// then pulses fifo_read/done_tick to clear the source FIFO.
module uart_tx_packet_sender
  import uart_pkg::*;
#(
  parameter int DATA_SIZE      = DEF_DATA_SIZE,
  parameter int ADDR_SPACE_EXP = DEF_ADDR_SPACE_EXP
) (
  input  logic                                      clk_100Mhz,
  input  logic                                      reset,
  input  logic                                      send,
  input  logic [DATA_SIZE*(2**ADDR_SPACE_EXP)-1:0]  packet_in,
  input  logic [ADDR_SPACE_EXP:0]                   byte_count,
  input  logic                                      tx_done_tick,
  output logic                                      tx_start,
  output logic [DATA_SIZE-1:0]                      tx_data,
  output logic                                      fifo_read,
  output logic                                      busy,
  output logic                                      done_tick
);

  localparam int unsigned BUF_DEPTH = 2**ADDR_SPACE_EXP;
  localparam int          PKT_W     = DATA_SIZE*(2**ADDR_SPACE_EXP);
  localparam int          CNT_W     = ADDR_SPACE_EXP+1;

  tx_state_t        state;
  logic [PKT_W-1:0] shreg;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] count_clamped;

  assign count_clamped = CNT_W'(clamp_count(32'(byte_count), BUF_DEPTH));

  // All outputs are registered alongside the state so they are pure Moore.
  always_ff @(posedge clk_100Mhz or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      remaining <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      fifo_read <= 1'b0;
      done_tick <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (send && (count_clamped != '0)) begin
            state     <= SEND;
            shreg     <= packet_in;
            remaining <= count_clamped;
            tx_data   <= packet_in[DATA_SIZE-1:0];
            tx_start  <= 1'b1;
            busy      <= 1'b1;
          end
        end
        SEND: begin
          state    <= WAIT;
          tx_start <= 1'b0;
        end
        WAIT: begin
          if (tx_done_tick) begin
            if (remaining == CNT_W'(1)) begin
              state     <= FINISH;
              fifo_read <= 1'b1;
              done_tick <= 1'b1;
            end else begin
              state     <= SEND;
              shreg     <= shreg >> DATA_SIZE;
              tx_data   <= shreg[DATA_SIZE +: DATA_SIZE];
              remaining <= remaining - CNT_W'(1);
              tx_start  <= 1'b1;
            end
          end
        end
        FINISH: begin
          state     <= IDLE;
          fifo_read <= 1'b0;
          done_tick <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          tx_start  <= 1'b0;
          fifo_read <= 1'b0;
          done_tick <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_packet_sender.md
# uart_tx_packet_sender

Drains a packed multi-byte buffer into the UART transmitter one byte at a time. It is the transmit-side counterpart of the receive FIFO: it takes the FIFO's parallel packed word and valid byte count, sequences bytes 0..N-1 into the UART TX core using a start/done handshake, and then pulses the FIFO's read/clear input. It sits between the packet FIFO and the UART TX core in the loopback/echo path.

## Interface
Parameters:
- DATA_SIZE, 8: bits per byte/word.
- ADDR_SPACE_EXP, 3: buffer depth is 2**ADDR_SPACE_EXP words (8).

Ports:
- clk_100Mhz, in, 1: system clock. All logic runs on its rising edge.
- reset, in, 1: asynchronous, active-high reset.
- send, in, 1: request to transmit the packet. Sampled only in IDLE.
- packet_in, in, DATA_SIZE*2**ADDR_SPACE_EXP (64): packed buffer. Word k occupies [DATA_SIZE*k +: DATA_SIZE]. Word 0 is sent first.
- byte_count, in, ADDR_SPACE_EXP+1 (4): number of valid words, 0..8. Values above 8 are clamped to 8.
- tx_done_tick, in, 1: one-cycle pulse from the UART TX core when the current byte has finished.
- tx_start, out, 1: one-cycle pulse that starts the UART TX core on tx_data.
- tx_data, out, DATA_SIZE: byte being sent. Held stable from tx_start until the next byte is loaded.
- fifo_read, out, 1: one-cycle pulse that clears the source FIFO after the last byte completes.
- busy, out, 1: high in every state except IDLE.
- done_tick, out, 1: one-cycle pulse that coincides with fifo_read.

## Operation
- States: IDLE, SEND, WAIT, FINISH. The state is registered and all outputs are Moore.
- IDLE:
  - If send=1 and the clamped count is nonzero: latch packet_in into the shift register, latch count into remaining, go to SEND.
  - If send=1 and count=0: stay in IDLE and generate no pulses.
- SEND: tx_start=1 for exactly one cycle, then go to WAIT. tx_data = shreg[DATA_SIZE-1:0].
- WAIT: hold until tx_done_tick=1. On the pulse:
  - If remaining==1, go to FINISH.
  - Otherwise shift shreg right by DATA_SIZE, decrement remaining, and go to SEND.
- FINISH: fifo_read=1 and done_tick=1 for one cycle, then go to IDLE.
- Event handling:
  - send is ignored outside IDLE. There is no queuing.
  - tx_done_tick is ignored outside WAIT.
  - packet_in and byte_count changes after the latch do not affect the transfer in progress.
- remaining is ADDR_SPACE_EXP+1 bits wide and never wraps, because count≥1 is guaranteed on entry.
- Reset in any state returns to IDLE immediately. No fifo_read or done_tick pulse is produced for the aborted transfer.

## Timing
- Reset values: state=IDLE, tx_start=0, tx_data=0, fifo_read=0, busy=0, done_tick=0, shreg=0, remaining=0.
- send=1 sampled at edge E: SEND is active and tx_start=1 during the cycle after E. busy rises at that same cycle.
- tx_done_tick at edge M (not the last byte): the next tx_start is high in the cycle after M. The inter-byte overhead is 1 cycle.
- Last tx_done_tick at edge M: FINISH (fifo_read, done_tick) is high in the cycle after M. IDLE with busy=0 follows one cycle later.
- Minimum total latency for N bytes, counted from the send edge to FINISH, is 2N+1 cycles when tx_done_tick arrives the cycle after tx_start.
- tx_data changes only on the SEND-entry edge, i.e. on latch or shift.

## Structure
- Shared package `uart_pkg`:
  - state encoding localparams: IDLE=2'd0, SEND=2'd1, WAIT=2'd2, FINISH=2'd3.
  - DEPTH = 2**ADDR_SPACE_EXP.
  - PACKED_W = DATA_SIZE*DEPTH.
- Single module. The state register, shift register and remaining counter are inline. No sub-module is warranted.
- The count clamp is a combinational function in the package, so the FIFO side and the TX side share it.

## Test plan
- Reset mid-WAIT of a 5-byte transfer. Required: all outputs return to reset values, no fifo_read pulse, and a subsequent send starts from byte 0.
- packet_in=64'h0807060504030201, count=3, TX model returns tx_done_tick 10 cycles after each tx_start. Required:
  - tx_start pulses exactly 3 times, with tx_data=01, 02, 03 in that order.
  - fifo_read and done_tick pulse once, one cycle after the 3rd tx_done_tick.
- count=8, with tx_done_tick the cycle after each tx_start. Required: 8 bytes 01..08, fifo_read 17 cycles after the send edge, busy low one cycle later.
- count=0 with send=1. Required: busy stays 0, and there are no tx_start, fifo_read or done_tick pulses.
- count=4'd12 with packet 64'hF8F7F6F5F4F3F2F1. Required: clamped to 8 bytes, F1..F8 sent.
- Stray pulses: send re-asserted and packet_in changed during WAIT, plus a stray tx_done_tick in IDLE. Required: the in-flight bytes are unchanged, no second transfer starts, and the IDLE tick causes no state change.
